// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of the UART receiver: pop request, FIFO head word and FIFO status.
// The consumer holds the master modport and the receiver holds the slave modport.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rd;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 full;

    modport master (output rd, input rd_data, rd_valid, full);
    modport slave  (input rd, output rd_data, rd_valid, full);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (runtime bit period, optional parity) feeding a small receive FIFO with sticky errors.
// A word is poppable the cycle after its stop sample; a word arriving while full is dropped and flagged as overrun.
module uart_rx_fifo #(
    parameter int DIV_W      = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] div,
    input  logic             err_clr,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    uart_rx_fifo_if.slave    rif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic                 rx_m, rx_s, rx_p;
    logic [2:0]           state;
    logic [DIV_W-1:0]     cnt, div_l;
    logic [BW-1:0]        bitn;
    logic [DATA_BITS-1:0] sh;
    logic                 par_bad;
    logic                 sample, stop_smp, exp_par;
    logic                 pop, push, set_fe, set_pe, set_ov;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wptr, rptr, rptr_nx;
    logic [CW-1:0]        count, cnt_nx;
    logic [DATA_BITS-1:0] rd_data_q, head_nx;
    logic                 full_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    assign sample   = (cnt == '0);
    assign stop_smp = (state == S_STOP) && sample;
    assign exp_par  = (PARITY == 2) ? ~^sh : ^sh;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            div_l   <= '0;
            bitn    <= '0;
            sh      <= '0;
            par_bad <= 1'b0;
        end else begin
            if (state != S_IDLE)
                cnt <= sample ? div_l - 1'b1 : cnt - 1'b1;
            case (state)
                S_IDLE: begin
                    // a falling edge is required, so a line stuck low cannot retrigger
                    if (rx_p && !rx_s) begin
                        div_l   <= div;
                        cnt     <= (div >> 1) - 1'b1;
                        bitn    <= '0;
                        par_bad <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: if (sample) state <= rx_s ? S_IDLE : S_DATA;
                S_DATA: begin
                    if (sample) begin
                        sh   <= {rx_s, sh[DATA_BITS-1:1]};
                        bitn <= bitn + 1'b1;
                        if (bitn == BW'(DATA_BITS - 1))
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (sample) begin
                        par_bad <= (rx_s != exp_par);
                        state   <= S_STOP;
                    end
                end
                S_STOP:  if (sample) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign full_w = (count == CW'(FIFO_DEPTH));
    assign pop    = rif.rd && (count != '0);
    assign set_fe = stop_smp && !rx_s;
    assign set_pe = stop_smp && rx_s && par_bad;
    assign set_ov = stop_smp && rx_s && !par_bad && full_w && !pop;
    assign push   = stop_smp && rx_s && !par_bad && (!full_w || pop);

    // rd_data is registered, so compute what the head will be after this edge
    always_comb begin
        rptr_nx = pop ? rptr + 1'b1 : rptr;
        cnt_nx  = count + CW'(push) - CW'(pop);
        if (push && (count == CW'(pop)))
            head_nx = sh;
        else if (cnt_nx == '0)
            head_nx = '0;
        else
            head_nx = mem[rptr_nx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd_data_q <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= sh;
                wptr      <= wptr + 1'b1;
            end
            rptr      <= rptr_nx;
            count     <= cnt_nx;
            rd_data_q <= head_nx;
        end
    end

    // a new error in the clearing cycle must survive the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= set_fe | (frame_err  & ~err_clr);
            parity_err <= set_pe | (parity_err & ~err_clr);
            overrun    <= set_ov | (overrun    & ~err_clr);
        end
    end

    assign rif.rd_data  = rd_data_q;
    assign rif.rd_valid = (count != '0);
    assign rif.full     = full_w;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: a no-parity/depth-4 receiver and an even-parity receiver driven with bit-accurate frames.
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        rst_n, rx0, rx1, err_clr0, err_clr1;
    logic [15:0] div;
    logic        busy0, fe0, pe0, ov0;
    logic        busy1, fe1, pe1, ov1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if1 ();

    uart_rx_fifo #(.DIV_W(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .div(div), .err_clr(err_clr0),
        .busy(busy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .rif(if0));

    uart_rx_fifo #(.DIV_W(16), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .div(div), .err_clr(err_clr1),
        .busy(busy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .rif(if1));

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic b);
        if (sel == 0) rx0 = b;
        else          rx1 = b;
    endtask

    // stop sample lands 3 + div/2 cycles into the stop bit (2 sync edges + detect + half bit)
    task automatic send_frame(input int sel, input logic [7:0] data, input bit with_par,
                              input logic par_bit, input logic stop_bit, input bit rd_at_stop);
        int d;
        d = int'(div);
        drive(sel, 1'b0); hold(d);
        for (int i = 0; i < 8; i++) begin
            drive(sel, data[i]); hold(d);
        end
        if (with_par) begin
            drive(sel, par_bit); hold(d);
        end
        drive(sel, stop_bit);
        if (rd_at_stop) begin
            hold(2 + d / 2);
            if0.rd = 1'b1; hold(1); if0.rd = 1'b0;
            hold(d - 3 - d / 2);
        end else begin
            hold(d);
        end
        drive(sel, 1'b1);
    endtask

    task automatic pop0();
        if0.rd = 1'b1; hold(1); if0.rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; err_clr0 = 1'b0; err_clr1 = 1'b0;
        if0.rd = 1'b0; if1.rd = 1'b0; div = 16'd8;
        hold(3);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", if0.rd_valid); end
        checks++; if (if0.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", if0.full); end
        checks++; if (if0.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", if0.rd_data); end
        checks++; if ({fe0, pe0, ov0, pe1} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {fe0, pe0, ov0, pe1}); end
        rst_n = 1'b1;
        hold(3);
    endtask

    task automatic test_basic();
        div = 16'd8;
        send_frame(0, 8'h55, 0, 1'b0, 1'b1, 0);
        send_frame(0, 8'hA3, 0, 1'b0, 1'b1, 0);
        checks++; if (if0.rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", if0.rd_valid); end
        checks++; if (if0.rd_data !== 8'h55) begin errors++; $display("FAIL basic_first: got %h want 55", if0.rd_data); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy0); end
        pop0();
        checks++; if (if0.rd_data !== 8'hA3) begin errors++; $display("FAIL basic_second: got %h want a3", if0.rd_data); end
        pop0();
        checks++; if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid: got %b want 0", if0.rd_valid); end
        checks++; if (if0.rd_data !== 8'h00) begin errors++; $display("FAIL basic_empty_data: got %h want 00", if0.rd_data); end
        checks++; if ({fe0, pe0, ov0} !== 3'b0) begin errors++; $display("FAIL basic_flags: got %b want 000", {fe0, pe0, ov0}); end
    endtask

    task automatic test_glitch();
        div = 16'd8;
        rx0 = 1'b0; hold(2); rx0 = 1'b1; hold(2);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy0); end
        hold(10);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy0); end
        checks++; if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_push: got %b want 0", if0.rd_valid); end
        checks++; if ({fe0, pe0, ov0} !== 3'b0) begin errors++; $display("FAIL glitch_flags: got %b want 000", {fe0, pe0, ov0}); end
    endtask

    task automatic test_frame_err();
        div = 16'd8;
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 0);
        hold(4);
        checks++; if (fe0 !== 1'b1) begin errors++; $display("FAIL frame_err_set: got %b want 1", fe0); end
        checks++; if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL frame_err_discard: got %b want 0", if0.rd_valid); end
        err_clr0 = 1'b1; hold(1); err_clr0 = 1'b0;
        checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL frame_err_clear: got %b want 0", fe0); end
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 0);
        checks++; if (if0.rd_data !== 8'h3C) begin errors++; $display("FAIL frame_err_recover: got %h want 3c", if0.rd_data); end
        checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL frame_err_stays_clear: got %b want 0", fe0); end
        pop0();
        checks++; if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL frame_err_popped: got %b want 0", if0.rd_valid); end
    endtask

    task automatic test_overrun();
        div = 16'd8;
        for (int v = 1; v <= 5; v++) begin
            send_frame(0, 8'(v), 0, 1'b0, 1'b1, 0);
            if (v == 4) begin
                checks++; if (if0.full !== 1'b1) begin errors++; $display("FAIL ovr_full_after4: got %b want 1", if0.full); end
                checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", ov0); end
            end
        end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", ov0); end
        for (int v = 1; v <= 4; v++) begin
            checks++; if (if0.rd_data !== 8'(v)) begin errors++; $display("FAIL ovr_pop_%0d: got %h want %h", v, if0.rd_data, 8'(v)); end
            pop0();
        end
        checks++; if (if0.rd_valid !== 1'b0 || if0.full !== 1'b0) begin errors++; $display("FAIL ovr_drained: got valid=%b full=%b want 0 0", if0.rd_valid, if0.full); end
        err_clr0 = 1'b1; hold(1); err_clr0 = 1'b0;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", ov0); end

        for (int v = 1; v <= 4; v++) send_frame(0, 8'(v), 0, 1'b0, 1'b1, 0);
        send_frame(0, 8'h05, 0, 1'b0, 1'b1, 1);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ovr_pop_same_cycle: got %b want 0", ov0); end
        checks++; if (if0.full !== 1'b1) begin errors++; $display("FAIL ovr_still_full: got %b want 1", if0.full); end
        for (int v = 2; v <= 5; v++) begin
            checks++; if (if0.rd_data !== 8'(v)) begin errors++; $display("FAIL ovr_keep_%0d: got %h want %h", v, if0.rd_data, 8'(v)); end
            pop0();
        end
        checks++; if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL ovr_final_empty: got %b want 0", if0.rd_valid); end
    endtask

    task automatic test_parity();
        div = 16'd8;
        // 0x07 has three ones, so the even-parity bit must be 1
        send_frame(1, 8'h07, 1, 1'b0, 1'b1, 0);
        checks++; if (pe1 !== 1'b1) begin errors++; $display("FAIL parity_bad_flag: got %b want 1", pe1); end
        checks++; if (if1.rd_valid !== 1'b0) begin errors++; $display("FAIL parity_bad_discard: got %b want 0", if1.rd_valid); end
        checks++; if (fe1 !== 1'b0) begin errors++; $display("FAIL parity_no_frame_err: got %b want 0", fe1); end
        err_clr1 = 1'b1; hold(1); err_clr1 = 1'b0;
        send_frame(1, 8'h07, 1, 1'b1, 1'b1, 0);
        checks++; if (if1.rd_data !== 8'h07 || if1.rd_valid !== 1'b1) begin errors++; $display("FAIL parity_good_push: got %h/%b want 07/1", if1.rd_data, if1.rd_valid); end
        checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL parity_good_flag: got %b want 0", pe1); end
        checks++; if (pe0 !== 1'b0) begin errors++; $display("FAIL parity_none_mode: got %b want 0", pe0); end
    endtask

    task automatic test_reset_mid();
        div = 16'd16;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, 0);
        checks++; if (if0.rd_data !== 8'h11) begin errors++; $display("FAIL rstmid_preload: got %h want 11", if0.rd_data); end
        rx0 = 1'b0; hold(16); rx0 = 1'b1; hold(40);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rstmid_in_frame: got %b want 1", busy0); end
        rst_n = 1'b0; #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
        checks++; if (if0.rd_valid !== 1'b0 || if0.rd_data !== 8'h00) begin errors++; $display("FAIL rstmid_fifo: got %b/%h want 0/00", if0.rd_valid, if0.rd_data); end
        checks++; if ({fe0, pe0, ov0, if0.full} !== 4'b0) begin errors++; $display("FAIL rstmid_flags: got %b want 0000", {fe0, pe0, ov0, if0.full}); end
        hold(3); rst_n = 1'b1; hold(3);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1, 0);
        checks++; if (if0.rd_data !== 8'h81 || if0.rd_valid !== 1'b1) begin errors++; $display("FAIL rstmid_after: got %h/%b want 81/1", if0.rd_data, if0.rd_valid); end
        checks++; if ({fe0, pe0, ov0} !== 3'b0) begin errors++; $display("FAIL rstmid_after_flags: got %b want 000", {fe0, pe0, ov0}); end
        pop0();
        checks++; if (if0.rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_single: got %b want 0", if0.rd_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_parity();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
